fifo_drain_fsm: RTL and testbench

Pixel-side consumer of the HDMI output line FIFO. It pops one 32-bit word per pixel slot from the first-word-fall-through FIFO and presents 24-bit RGB to the HDMI core. It generates the half_full, hsync and vsync pulses that drive the DDR fill FSM's address stepping. It also counts pixels and lines per frame, and flags FIFO underflow.

---
 rtl/fifo_drain_if.sv | 11 +
 rtl/fifo_drain_fsm.sv | 108 ++++++++++
 tb/tb_fifo_drain_fsm.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_if.sv
// FIFO-read and pixel-output bundle between the line FIFO, the drain FSM and the HDMI core.
interface fifo_drain_if;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic [23:0] pixel_data;
  logic        pixel_valid;

  modport master (input fifo_empty, fifo_rd_data, output fifo_rd_en, pixel_data, pixel_valid);
  modport slave  (output fifo_empty, fifo_rd_data, input fifo_rd_en, pixel_data, pixel_valid);
endinterface

// File: rtl/fifo_drain_fsm.sv
// Pixel-side drain of the HDMI line FIFO: pops one word per pixel slot, emits RGB,
// half_full/hsync/vsync stepping pulses for the DDR fill side, and a sticky underflow flag.
module fifo_drain_fsm #(
  parameter int HALF_WORDS = 64,
  parameter int CNT_W      = 16
) (
  input  logic             Bus2IP_Clk,
  input  logic             Bus2IP_Reset,
  input  logic             start_drain,
  input  logic             pixel_en,
  input  logic [31:0]      NUM_PIXELS_PER_LINE,
  input  logic [31:0]      NUM_LINES_PER_FRAME,
  fifo_drain_if.master     fifo,
  output logic             half_full,
  output logic             hsync,
  output logic             vsync,
  output logic             underflow,
  output logic             busy,
  output logic [CNT_W-1:0] line_count
);

  typedef enum logic [1:0] {IDLE, PRIME, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pix_cnt, half_cnt, npx, nln;
  logic             start_ok, slot, pop, line_end, frame_end, half_hit;
  logic             unused_hi;

  assign npx = NUM_PIXELS_PER_LINE[CNT_W-1:0];
  assign nln = NUM_LINES_PER_FRAME[CNT_W-1:0];
  assign unused_hi = ^{NUM_PIXELS_PER_LINE[31:CNT_W], NUM_LINES_PER_FRAME[31:CNT_W],
                       fifo.fifo_rd_data[31:24]};

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    start_ok        = 1'b0;
    slot            = 1'b0;
    pop             = 1'b0;
    line_end        = 1'b0;
    frame_end       = 1'b0;
    half_hit        = 1'b0;
    busy            = (state != IDLE);
    fifo.fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        start_ok = start_drain && (npx != '0) && (nln != '0);
        if (start_ok) state_nxt = PRIME;
      end
      PRIME: begin
        if (!fifo.fifo_empty) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        // Pop is gated by reset so the FIFO never loses a word on the reset edge.
        slot      = pixel_en && !Bus2IP_Reset;
        pop       = slot && !fifo.fifo_empty;
        line_end  = slot && (pix_cnt == npx - CNT_W'(1));
        frame_end = line_end && (line_count == nln - CNT_W'(1));
        half_hit  = pop && (half_cnt == CNT_W'(HALF_WORDS - 1));
        if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    fifo.fifo_rd_en = pop;
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      pix_cnt          <= '0;
      half_cnt         <= '0;
      line_count       <= '0;
      fifo.pixel_data  <= '0;
      fifo.pixel_valid <= 1'b0;
      half_full        <= 1'b0;
      hsync            <= 1'b0;
      vsync            <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      fifo.pixel_valid <= slot;
      // Sync pulses outrank half_full so the fill side never sees two steps at once.
      half_full        <= half_hit && !line_end;
      hsync            <= line_end && !frame_end;
      vsync            <= frame_end;
      if (slot) fifo.pixel_data <= pop ? fifo.fifo_rd_data[23:0] : 24'h0;
      if (start_ok) begin
        underflow  <= 1'b0;
        pix_cnt    <= '0;
        half_cnt   <= '0;
        line_count <= '0;
      end else if (slot) begin
        if (fifo.fifo_empty) underflow <= 1'b1;
        if (line_end) begin
          pix_cnt    <= '0;
          half_cnt   <= '0;
          line_count <= frame_end ? '0 : line_count + CNT_W'(1);
        end else begin
          pix_cnt <= pix_cnt + CNT_W'(1);
          if (pop) half_cnt <= half_hit ? '0 : half_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_fsm.sv
// Scoreboarded bench: two drains (HALF_WORDS 4 and 64) share one FIFO model and stimulus.
module tb_fifo_drain_fsm;
  logic        clk = 1'b0;
  logic        rst, start, pen;
  logic [31:0] npx, nln;
  bit          force_empty, auto_fill;
  logic [31:0] fifo_q[$];
  int          checks = 0, errors = 0;
  int          n_pops, n_valid, n_half_a, n_half_b, n_hs, n_vs;
  int          m_st, m_slot, m_pops, m_line;
  bit          m_unf;

  logic        half_a, hs_a, vs_a, unf_a, busy_a, half_b, hs_b, vs_b, unf_b, busy_b;
  logic [15:0] line_a, line_b;

  typedef struct packed {
    logic rd, rd_a, rd_b, valid, chk, half_a, half_b, hs, vs, unf, busy;
    logic [23:0] data;
    logic [15:0] line;
  } exp_t;
  exp_t sbq[$];
  exp_t me;

  fifo_drain_if fa();
  fifo_drain_if fb();

  fifo_drain_fsm #(.HALF_WORDS(4), .CNT_W(16)) dut_a (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .start_drain(start), .pixel_en(pen),
    .NUM_PIXELS_PER_LINE(npx), .NUM_LINES_PER_FRAME(nln), .fifo(fa),
    .half_full(half_a), .hsync(hs_a), .vsync(vs_a), .underflow(unf_a), .busy(busy_a),
    .line_count(line_a));

  fifo_drain_fsm #(.HALF_WORDS(64), .CNT_W(16)) dut_b (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .start_drain(start), .pixel_en(pen),
    .NUM_PIXELS_PER_LINE(npx), .NUM_LINES_PER_FRAME(nln), .fifo(fb),
    .half_full(half_b), .hsync(hs_b), .vsync(vs_b), .underflow(unf_b), .busy(busy_b),
    .line_count(line_b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard consumer: each cycle's expectation is checked at the following falling edge.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      me = sbq.pop_front();
      checks++;
      if ({me.rd_a, me.rd_b} !== {2{me.rd}}) begin
        errors++; $display("FAIL rd_en got=%b%b exp=%b t=%0t", me.rd_a, me.rd_b, me.rd, $time);
      end
      checks++;
      if ({fa.pixel_valid, half_a, hs_a, vs_a, unf_a, busy_a} !==
          {me.valid, me.half_a, me.hs, me.vs, me.unf, me.busy}) begin
        errors++;
        $display("FAIL ctl_a got=%b exp=%b t=%0t", {fa.pixel_valid, half_a, hs_a, vs_a, unf_a, busy_a},
                 {me.valid, me.half_a, me.hs, me.vs, me.unf, me.busy}, $time);
      end
      checks++;
      if ({fb.pixel_valid, half_b, hs_b, vs_b, unf_b, busy_b} !==
          {me.valid, me.half_b, me.hs, me.vs, me.unf, me.busy}) begin
        errors++;
        $display("FAIL ctl_b got=%b exp=%b t=%0t", {fb.pixel_valid, half_b, hs_b, vs_b, unf_b, busy_b},
                 {me.valid, me.half_b, me.hs, me.vs, me.unf, me.busy}, $time);
      end
      checks++;
      if ({line_a, line_b} !== {2{me.line}}) begin
        errors++; $display("FAIL line_count got=%0d/%0d exp=%0d t=%0t", line_a, line_b, me.line, $time);
      end
      if (me.chk) begin
        checks++;
        if ({fa.pixel_data, fb.pixel_data} !== {2{me.data}}) begin
          errors++;
          $display("FAIL pixel_data got=%h/%h exp=%h t=%0t", fa.pixel_data, fb.pixel_data, me.data, $time);
        end
      end
    end
  end

  // One clock of stimulus: present the FIFO head, predict the outputs, push, advance.
  task automatic cycle();
    exp_t        e;
    logic [31:0] head;
    logic        emp, slot, pop, last;
    int          np, nl;
    if (auto_fill) while (fifo_q.size() < 4) fifo_q.push_back($urandom);
    head = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    emp  = force_empty || (fifo_q.size() == 0);
    fa.fifo_empty = emp;  fb.fifo_empty = emp;
    fa.fifo_rd_data = head; fb.fifo_rd_data = head;
    #1;
    np   = int'(npx[15:0]);
    nl   = int'(nln[15:0]);
    slot = !rst && (m_st == 2) && pen;
    pop  = slot && !emp;
    last = slot && (m_slot + 1 == np);
    e        = '0;
    e.rd     = pop;
    e.rd_a   = fa.fifo_rd_en;
    e.rd_b   = fb.fifo_rd_en;
    e.valid  = slot;
    e.chk    = slot || rst;
    e.data   = pop ? head[23:0] : 24'h0;
    e.half_a = pop && !last && ((m_pops + 1) % 4 == 0);
    e.half_b = pop && !last && ((m_pops + 1) % 64 == 0);
    e.hs     = last && (m_line + 1 != nl);
    e.vs     = last && (m_line + 1 == nl);
    if (rst) begin
      m_st = 0; m_slot = 0; m_pops = 0; m_line = 0; m_unf = 0;
    end else if (m_st == 0) begin
      if (start && np != 0 && nl != 0) begin
        m_st = 1; m_slot = 0; m_pops = 0; m_line = 0; m_unf = 0;
      end
    end else if (m_st == 1) begin
      if (!emp) m_st = 2;
    end else if (slot) begin
      if (emp) m_unf = 1;
      if (pop) m_pops++;
      m_slot++;
      if (last) begin
        m_slot = 0; m_pops = 0;
        if (e.vs) begin m_line = 0; m_st = 0; end
        else m_line++;
      end
    end
    e.unf  = m_unf;
    e.busy = (m_st != 0);
    e.line = 16'(m_line);
    sbq.push_back(e);
    @(posedge clk);
    if (e.rd_a && fifo_q.size() != 0) begin head = fifo_q.pop_front(); n_pops++; end
    @(negedge clk);
    if (fa.pixel_valid) n_valid++;
    if (half_a) n_half_a++;
    if (half_b) n_half_b++;
    if (hs_a) n_hs++;
    if (vs_a) n_vs++;
  endtask

  task automatic clear_tally();
    n_pops = 0; n_valid = 0; n_half_a = 0; n_half_b = 0; n_hs = 0; n_vs = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic run_to_idle(input int bound);
    int k = 0;
    pen = 1'b1;
    while (m_st != 0 && k < bound) begin cycle(); k++; end
    checks++;
    if (busy_a !== 1'b0 || k >= bound) begin
      errors++; $display("FAIL run_to_idle busy=%b cycles=%0d bound=%0d", busy_a, k, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pen = 1'b0; npx = 32'd8; nln = 32'd2;
    force_empty = 0; auto_fill = 0;
    cycle(); cycle();
    checks++;
    if ({fa.pixel_data, fa.pixel_valid, half_a, hs_a, vs_a, unf_a, busy_a, line_a, fa.fifo_rd_en} !== '0) begin
      errors++; $display("FAIL reset_state outputs not all zero t=%0t", $time);
    end
    rst = 1'b0; cycle();
  endtask

  task automatic test_basic_frame();
    clear_tally();
    npx = 32'd8; nln = 32'd2; auto_fill = 0;
    for (int i = 0; i < 16; i++) fifo_q.push_back({8'hC3, 24'(i * 24'h010305 + 24'h0A0B0C)});
    pen = 1'b1;
    pulse_start();
    run_to_idle(40);
    checks++;
    if (n_pops != 16 || fifo_q.size() != 0) begin
      errors++; $display("FAIL basic_pops got=%0d left=%0d exp=16/0", n_pops, fifo_q.size());
    end
    checks++;
    if ({n_half_a, n_hs, n_vs} !== {32'd2, 32'd1, 32'd1}) begin
      errors++; $display("FAIL basic_pulses half=%0d hs=%0d vs=%0d exp=2/1/1", n_half_a, n_hs, n_vs);
    end
  endtask

  task automatic test_long_line();
    clear_tally();
    npx = 32'd640; nln = 32'd2; auto_fill = 1;
    pen = 1'b1;
    pulse_start();
    run_to_idle(1400);
    checks++;
    if ({n_half_b, n_half_a, n_hs, n_vs} !== {32'd18, 32'd318, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL long_line half64=%0d half4=%0d hs=%0d vs=%0d exp=18/318/1/1", n_half_b, n_half_a, n_hs, n_vs);
    end
  endtask

  task automatic test_underflow();
    int  k = 0;
    bit  hit = 0;
    clear_tally();
    npx = 32'd8; nln = 32'd2; auto_fill = 1; pen = 1'b1;
    pulse_start();
    while (m_st != 0 && k < 60) begin
      force_empty = (m_st == 2) && (m_slot == 3) && (m_line == 0);
      hit = force_empty;
      cycle(); k++;
      if (hit) begin
        checks++;
        if ({fa.pixel_valid, fa.pixel_data, unf_a} !== {1'b1, 24'h0, 1'b1}) begin
          errors++;
          $display("FAIL underflow_slot valid=%b data=%h unf=%b exp=1/000000/1", fa.pixel_valid, fa.pixel_data, unf_a);
        end
      end
    end
    force_empty = 0;
    checks++;
    if ({unf_a, unf_b, n_hs, n_vs, n_valid, n_pops} !== {1'b1, 1'b1, 32'd1, 32'd1, 32'd16, 32'd15}) begin
      errors++;
      $display("FAIL underflow_frame unf=%b hs=%0d vs=%0d valid=%0d pops=%0d exp=1/1/1/16/15",
               unf_a, n_hs, n_vs, n_valid, n_pops);
    end
    pulse_start();
    checks++;
    if (unf_a !== 1'b0) begin errors++; $display("FAIL underflow_clear got=%b exp=0", unf_a); end
    run_to_idle(60);
  endtask

  task automatic test_prime_wait();
    clear_tally();
    npx = 32'd8; nln = 32'd2; auto_fill = 0; fifo_q.delete(); pen = 1'b1;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if ({busy_a, fa.pixel_valid} !== 2'b10 || n_pops != 0) begin
        errors++; $display("FAIL prime_hold busy=%b valid=%b pops=%0d exp=1/0/0", busy_a, fa.pixel_valid, n_pops);
      end
    end
    for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
    cycle();
    checks++;
    if ({busy_a, fa.pixel_valid, n_pops} !== {1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL prime_exit valid=%b pops=%0d exp=0/0", fa.pixel_valid, n_pops);
    end
    cycle();
    checks++;
    if (fa.pixel_valid !== 1'b1) begin errors++; $display("FAIL prime_active valid=%b exp=1", fa.pixel_valid); end
    auto_fill = 1;
    run_to_idle(60);
  endtask

  task automatic test_reset_midline();
    int k = 0;
    clear_tally();
    npx = 32'd8; nln = 32'd2; auto_fill = 1; pen = 1'b1;
    pulse_start();
    while (!(m_st == 2 && m_line == 1 && m_slot == 5) && k < 60) begin
      force_empty = (m_st == 2) && (m_slot == 2) && (m_line == 0);
      cycle(); k++;
    end
    force_empty = 0;
    checks++;
    if ({line_a, unf_a, busy_a} !== {16'd1, 1'b1, 1'b1}) begin
      errors++; $display("FAIL pre_reset line=%0d unf=%b busy=%b exp=1/1/1", line_a, unf_a, busy_a);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if ({fa.pixel_data, fa.pixel_valid, half_a, hs_a, vs_a, unf_a, busy_a, line_a, fa.fifo_rd_en} !== '0) begin
      errors++; $display("FAIL midline_reset outputs not all zero t=%0t", $time);
    end
    rst = 1'b0;
    clear_tally();
    pulse_start();
    run_to_idle(60);
    checks++;
    if ({n_half_a, n_hs, n_vs, n_valid} !== {32'd2, 32'd1, 32'd1, 32'd16}) begin
      errors++; $display("FAIL post_reset_frame half=%0d hs=%0d vs=%0d valid=%0d exp=2/1/1/16",
                         n_half_a, n_hs, n_vs, n_valid);
    end
  endtask

  task automatic test_ignored_start();
    clear_tally();
    npx = 32'd0; nln = 32'd2; auto_fill = 1; pen = 1'b1;
    pulse_start();
    cycle(); cycle();
    checks++;
    if ({busy_a, fa.pixel_valid, n_pops} !== {1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL zero_px_start busy=%b valid=%b pops=%0d exp=0/0/0", busy_a, fa.pixel_valid, n_pops);
    end
    npx = 32'd8;
    pulse_start();
    for (int i = 0; i < 6; i++) cycle();
    pulse_start();
    run_to_idle(60);
    checks++;
    if ({n_valid, n_hs, n_vs, n_half_a} !== {32'd16, 32'd1, 32'd1, 32'd2}) begin
      errors++; $display("FAIL restart_ignored valid=%0d hs=%0d vs=%0d half=%0d exp=16/1/1/2",
                         n_valid, n_hs, n_vs, n_half_a);
    end
  endtask

  initial begin
    m_st = 0; m_slot = 0; m_pops = 0; m_line = 0; m_unf = 0;
    test_reset();
    test_basic_frame();
    test_long_line();
    test_underflow();
    test_prime_wait();
    test_reset_midline();
    test_ignored_start();
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
